// File: rtl/cond_pkg.sv
// Shared constants and channel-output bundle for the input conditioner.
package cond_pkg;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int DB_CYCLES_DEF   = 16;

   typedef struct packed {
      logic clean;
      logic rise;
      logic fall;
   } chan_out_t;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: synchronizer chain, debounce counter and
// registered rise/fall pulses.
module debounce_channel
   import cond_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic      clk,
   input  logic      rstN,
   input  logic      raw,
   output chan_out_t out
);

   localparam int CNT_W = $clog2(DB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   clean_q;
   logic                   rise_q;
   logic                   fall_q;
   logic                   sync;
   logic                   differ;
   logic                   hit;

   assign sync   = sync_q[SYNC_STAGES-1];
   assign differ = sync != clean_q;
   assign hit    = differ && (cnt_q == CNT_MAX);

   // Any cycle of agreement restarts the count, so bounce never accumulates.
   always_comb begin
      cnt_d = '0;
      if (differ && !hit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
         cnt_q   <= cnt_d;
         clean_q <= hit ? sync : clean_q;
         rise_q  <= hit && sync;
         fall_q  <= hit && !sync;
      end
   end

   assign out.clean = clean_q;
   assign out.rise  = rise_q;
   assign out.fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Two independent debounced inputs feeding the downstream FSM a/b inputs.
module input_conditioner
   import cond_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rstN,
   input  logic raw_a,
   input  logic raw_b,
   output logic clean_a,
   output logic clean_b,
   output logic rise_a,
   output logic rise_b,
   output logic fall_a,
   output logic fall_b
);

   chan_out_t ch_a;
   chan_out_t ch_b;

   debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
   ) u_a (
      .clk (clk),
      .rstN(rstN),
      .raw (raw_a),
      .out (ch_a)
   );

   debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
   ) u_b (
      .clk (clk),
      .rstN(rstN),
      .raw (raw_b),
      .out (ch_b)
   );

   assign clean_a = ch_a.clean;
   assign rise_a  = ch_a.rise;
   assign fall_a  = ch_a.fall;
   assign clean_b = ch_b.clean;
   assign rise_b  = ch_b.rise;
   assign fall_b  = ch_b.fall;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with SYNC_STAGES=2, DB_CYCLES=4.
module tb_input_conditioner;

   logic clk = 1'b0;
   logic rstN;
   logic raw_a;
   logic raw_b;
   logic clean_a;
   logic clean_b;
   logic rise_a;
   logic rise_b;
   logic fall_a;
   logic fall_b;

   int errors = 0;
   int checks = 0;

   input_conditioner #(
      .SYNC_STAGES(2),
      .DB_CYCLES  (4)
   ) dut (
      .clk    (clk),
      .rstN   (rstN),
      .raw_a  (raw_a),
      .raw_b  (raw_b),
      .clean_a(clean_a),
      .clean_b(clean_b),
      .rise_a (rise_a),
      .rise_b (rise_b),
      .fall_a (fall_a),
      .fall_b (fall_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge and settle past it before sampling/driving.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] outs();
      return {2'b00, clean_a, clean_b, rise_a, rise_b, fall_a, fall_b};
   endfunction

   initial begin
      rstN  = 1'b0;
      raw_a = 1'b1;
      raw_b = 1'b1;

      // Reset held with inputs high: every output stays 0.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_outs", outs(), 8'h00);
      end
      raw_a = 1'b0;
      raw_b = 1'b0;
      rstN  = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("idle_outs", outs(), 8'h00);

      // Clean step on A: clean/rise after edge 6, rise drops after edge 7.
      raw_a = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("step_clean_a_%0d", k), 8'(clean_a), 8'(k >= 6));
         chk($sformatf("step_rise_a_%0d", k), 8'(rise_a), 8'(k == 6));
         chk($sformatf("step_fall_a_%0d", k), 8'(fall_a), 8'h00);
         chk($sformatf("step_b_%0d", k),
             8'({clean_b, rise_b, fall_b}), 8'h00);
      end

      // Bounce on B: three cycles high, then low -> nothing happens.
      raw_b = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 3) raw_b = 1'b0;
         chk($sformatf("bounce_b_%0d", k),
             8'({clean_b, rise_b, fall_b}), 8'h00);
      end

      // Counter must have cleared: a real step still takes exactly 6 edges.
      raw_b = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("rearm_clean_b_%0d", k), 8'(clean_b), 8'(k >= 6));
         chk($sformatf("rearm_rise_b_%0d", k), 8'(rise_b), 8'(k == 6));
      end

      // Simultaneous fall on both channels.
      raw_a = 1'b0;
      raw_b = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("sim_fall_a_%0d", k), 8'(fall_a), 8'(k == 6));
         chk($sformatf("sim_fall_b_%0d", k), 8'(fall_b), 8'(k == 6));
         chk($sformatf("sim_clean_%0d", k),
             8'({clean_a, clean_b}), (k < 6) ? 8'h03 : 8'h00);
         chk($sformatf("sim_rise_%0d", k), 8'({rise_a, rise_b}), 8'h00);
      end

      // Reset mid-debounce: pending rise abandoned, restarts after release.
      raw_a = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         step();
         if (k == 4) rstN = 1'b0;
         if (k == 5) begin
            chk("midrst_outs", outs(), 8'h00);
            rstN = 1'b1;
         end
         chk($sformatf("midrst_rise_a_%0d", k), 8'(rise_a), 8'(k == 11));
         chk($sformatf("midrst_clean_a_%0d", k), 8'(clean_a), 8'(k >= 11));
      end

      raw_a = 1'b0;
      for (int i = 0; i < 8; i++) step();
      chk("pre_toggle_a", 8'({clean_a, rise_a, fall_a}), 8'h00);

      // Toggle every cycle: clean_a never moves, no pulses.
      for (int k = 1; k <= 100; k++) begin
         raw_a = ~raw_a;
         step();
         chk($sformatf("toggle_a_%0d", k),
             8'({clean_a, rise_a, fall_a}), 8'h00);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
